// File: rtl/el2_dec_trace_port_pkg.sv
// rtl/el2_dec_trace_port_pkg.sv - trace record type and width shared by the trace port slice
//
// Purpose: defines the packed 72-bit retire/trap record that is carried on the trace port.
// Record layout, MSB first: {ovf, intr, exc, vld, cause[4:0], mtval[31:0], pc[31:1]}

package el2_dec_trace_port_pkg;

  localparam int TRACE_REC_W = 72;

  typedef struct packed {
    logic        ovf;    // one or more records were lost just before this one
    logic        intr;   // interrupt taken
    logic        exc;    // exception taken
    logic        vld;    // instruction retired
    logic [4:0]  cause;
    logic [31:0] mtval;
    logic [31:1] pc;
  } el2_trace_rec_t;

endpackage

// File: rtl/el2_dec_trace_port_if.sv
// rtl/el2_dec_trace_port_if.sv - valid/ready trace port between the core and the trace encoder
//
// Purpose: bundles the trace record handshake.
// Ports (signals): trace_valid, trace_ready, trace_rec[TRACE_REC_W-1:0]
// Modports: master = record source (core side), slave = record sink (encoder side)

interface el2_dec_trace_port_if;
  import el2_dec_trace_port_pkg::*;

  logic                   trace_valid;
  logic                   trace_ready;
  logic [TRACE_REC_W-1:0] trace_rec;

  modport master (output trace_valid, output trace_rec, input trace_ready);
  modport slave  (input trace_valid, input trace_rec, output trace_ready);

endinterface

// File: rtl/el2_dec_trace_fifo.sv
// rtl/el2_dec_trace_fifo.sv - generic synchronous FIFO holding pending trace records
//
// Purpose: DEPTH-entry FIFO; the caller never pushes when full unless it pops in the same cycle.
// Ports: clk, rst_l (async active-low), push, pop, wdata[WIDTH], rdata[WIDTH] (head, 0 when
//        empty), full, empty

module el2_dec_trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Head is read from registered storage only, so nothing flows through from wdata.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/el2_dec_trace_port.sv
// rtl/el2_dec_trace_port.sv - captures TLU wb1 retire/trap records and serves them on a trace port
//
// Purpose: one record per cycle into a DEPTH-entry FIFO, drained over a valid/ready port;
//          records that arrive while the FIFO is full and not draining are counted as lost.
// Ports: clk, rst_l (async active-low); dec_tlu_i0_valid_wb1, dec_tlu_i0_exc_valid_wb1,
//        dec_tlu_int_valid_wb1, dec_tlu_exc_cause_wb1[5], dec_tlu_mtval_wb1[32], trace_pc_wb1[31];
//        dec_tlu_trace_disable, trace_drop_clr; tp (master: trace_valid/trace_ready/trace_rec);
//        trace_drop_cnt[DROP_W], trace_empty

module el2_dec_trace_port
  import el2_dec_trace_port_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   dec_tlu_i0_valid_wb1,
  input  logic                   dec_tlu_i0_exc_valid_wb1,
  input  logic                   dec_tlu_int_valid_wb1,
  input  logic [4:0]             dec_tlu_exc_cause_wb1,
  input  logic [31:0]            dec_tlu_mtval_wb1,
  input  logic [31:1]            trace_pc_wb1,
  input  logic                   dec_tlu_trace_disable,
  input  logic                   trace_drop_clr,
  el2_dec_trace_port_if.master   tp,
  output logic [DROP_W-1:0]      trace_drop_cnt,
  output logic                   trace_empty
);

  el2_trace_rec_t         rec_in;
  logic [TRACE_REC_W-1:0] rdata;
  logic                   full;
  logic                   empty;
  logic                   push_req;
  logic                   push_acc;
  logic                   pop;
  logic                   drop;
  logic                   drop_pending;

  assign push_req = !dec_tlu_trace_disable &
                    (dec_tlu_i0_valid_wb1 | dec_tlu_i0_exc_valid_wb1 | dec_tlu_int_valid_wb1);
  assign pop      = tp.trace_valid & tp.trace_ready;
  // A pop frees the slot this same cycle, so a full FIFO can still take a record.
  assign push_acc = push_req & (!full | pop);
  assign drop     = push_req & full & !pop;

  always_comb begin
    rec_in       = '0;
    rec_in.ovf   = drop_pending;
    rec_in.intr  = dec_tlu_int_valid_wb1;
    rec_in.exc   = dec_tlu_i0_exc_valid_wb1;
    rec_in.vld   = dec_tlu_i0_valid_wb1;
    rec_in.cause = dec_tlu_exc_cause_wb1;
    rec_in.mtval = dec_tlu_mtval_wb1;
    rec_in.pc    = trace_pc_wb1;
  end

  el2_dec_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push_acc),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign tp.trace_valid = !empty;
  assign tp.trace_rec   = rdata;
  assign trace_empty    = empty;

  // drop_pending marks the next accepted record so the encoder sees the gap.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      drop_pending   <= 1'b0;
      trace_drop_cnt <= '0;
    end else begin
      if (push_acc)  drop_pending <= 1'b0;
      else if (drop) drop_pending <= 1'b1;

      if (trace_drop_clr)
        trace_drop_cnt <= drop ? DROP_W'(1) : '0;
      else if (drop && (trace_drop_cnt != {DROP_W{1'b1}}))
        trace_drop_cnt <= trace_drop_cnt + DROP_W'(1);
    end
  end

endmodule
